// File: rtl/sga_button_conditioner_if.sv
// Direction-request handshake between the button conditioner and the game core.
// The conditioner (master) offers a held direction code with a valid flag;
// the consumer (slave) acknowledges it with a one-cycle ack.
interface sga_button_conditioner_if;
    logic       dir_valid;
    logic [1:0] dir_code;
    logic       dir_ack;

    modport master (
        output dir_valid,
        output dir_code,
        input  dir_ack
    );

    modport slave (
        input  dir_valid,
        input  dir_code,
        output dir_ack
    );
endinterface

// File: rtl/sga_button_conditioner.sv
// Button conditioner for the Snake Game Arcade.
// Each of the four active-low push-buttons passes through a 2-FF synchronizer
// and a debounce FSM that produces a clean level plus a one-cycle press pulse.
// The press pulses feed a priority arbiter that raises a held direction request,
// refusing reversals (and repeats) of the snake's current direction.
module sga_button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [3:0]                   buttons_raw,
    input  logic [1:0]                   current_dir,
    input  logic                         enable,
    sga_button_conditioner_if.master     dir_bus,
    output logic [3:0]                   buttons_clean,
    output logic [3:0]                   press_pulse,
    output logic [1:0]                   db_state
);

    typedef enum logic [1:0] {
        RELEASED     = 2'b00,
        PRESS_WAIT   = 2'b01,
        PRESSED      = 2'b10,
        RELEASE_WAIT = 2'b11
    } db_state_t;

    // The counter value from which one more increment reaches DEBOUNCE_CYCLES-1;
    // comparing against it lets the state change on the same edge the count lands.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);

    logic [3:0]      sync_meta_reg;
    logic [3:0]      sync_level_reg;
    logic [3:0][1:0] fsm_state;

    // Two-stage synchronizer; idles high because the buttons are active-low.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_meta_reg  <= 4'b1111;
            sync_level_reg <= 4'b1111;
        end else begin
            sync_meta_reg  <= buttons_raw;
            sync_level_reg <= sync_meta_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_btn
            db_state_t        state_reg, state_next;
            logic [CNT_W-1:0] cnt_reg, cnt_next;
            logic             clean_reg, clean_next;
            logic             pulse_reg, pulse_next;

            // Debounce state, counter, clean level and press pulse registers.
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    state_reg <= RELEASED;
                    cnt_reg   <= '0;
                    clean_reg <= 1'b1;
                    pulse_reg <= 1'b0;
                end else begin
                    state_reg <= state_next;
                    cnt_reg   <= cnt_next;
                    clean_reg <= clean_next;
                    pulse_reg <= pulse_next;
                end
            end

            // Debounce next-state: a level must persist for the full window,
            // any bounce back to the old level abandons the attempt.
            always_comb begin
                state_next = state_reg;
                cnt_next   = cnt_reg;
                clean_next = clean_reg;
                pulse_next = 1'b0;
                case (state_reg)
                    RELEASED: begin
                        if (!sync_level_reg[gi]) begin
                            state_next = PRESS_WAIT;
                            cnt_next   = '0;
                        end
                    end
                    PRESS_WAIT: begin
                        if (sync_level_reg[gi]) begin
                            state_next = RELEASED;
                        end else if (cnt_reg == CNT_LAST) begin
                            state_next = PRESSED;
                            cnt_next   = cnt_reg + CNT_W'(1);
                            clean_next = 1'b0;
                            pulse_next = 1'b1;
                        end else begin
                            cnt_next = cnt_reg + CNT_W'(1);
                        end
                    end
                    PRESSED: begin
                        if (sync_level_reg[gi]) begin
                            state_next = RELEASE_WAIT;
                            cnt_next   = '0;
                        end
                    end
                    RELEASE_WAIT: begin
                        if (!sync_level_reg[gi]) begin
                            state_next = PRESSED;
                        end else if (cnt_reg == CNT_LAST) begin
                            state_next = RELEASED;
                            cnt_next   = cnt_reg + CNT_W'(1);
                            clean_next = 1'b1;
                        end else begin
                            cnt_next = cnt_reg + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_next = RELEASED;
                        cnt_next   = '0;
                        clean_next = 1'b1;
                    end
                endcase
            end

            assign buttons_clean[gi] = clean_reg;
            assign press_pulse[gi]   = pulse_reg;
            assign fsm_state[gi]     = state_reg;
        end
    endgenerate

    assign db_state = fsm_state[3];

    logic       cand_valid;
    logic [1:0] cand_code;
    logic       cand_accept;
    logic       capture;
    logic       dir_valid_reg;
    logic [1:0] dir_code_reg;

    // Pick the highest-priority pulse (left > up > down > right). A rejected
    // candidate blocks the whole cycle rather than falling through. Opposite
    // and identical directions share bit 1, so one compare rejects both.
    always_comb begin
        cand_valid = 1'b1;
        cand_code  = 2'b01;
        if (press_pulse[3]) begin
            cand_code = 2'b00;
        end else if (press_pulse[2]) begin
            cand_code = 2'b10;
        end else if (press_pulse[1]) begin
            cand_code = 2'b11;
        end else if (press_pulse[0]) begin
            cand_code = 2'b01;
        end else begin
            cand_valid = 1'b0;
        end
        cand_accept = cand_valid && (cand_code[1] != current_dir[1]);
        capture     = cand_accept && enable && (!dir_valid_reg || dir_bus.dir_ack);
    end

    // Held request: first request wins until acked; a capture coincident with
    // an ack replaces the old request without dropping valid.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dir_valid_reg <= 1'b0;
            dir_code_reg  <= 2'b01;
        end else if (capture) begin
            dir_valid_reg <= 1'b1;
            dir_code_reg  <= cand_code;
        end else if (dir_valid_reg && dir_bus.dir_ack) begin
            dir_valid_reg <= 1'b0;
        end
    end

    assign dir_bus.dir_valid = dir_valid_reg;
    assign dir_bus.dir_code  = dir_code_reg;

endmodule

// File: tb/tb_sga_button_conditioner.sv
// Bench for the button conditioner with a short debounce window.
// Expected press pulses (cycle and vector) are queued when a press is driven
// and popped by a monitor whenever the DUT emits a pulse.
module tb_sga_button_conditioner;

    localparam int D = 8;

    logic       clock;
    logic       reset;
    logic [3:0] buttons_raw;
    logic [1:0] current_dir;
    logic       enable;
    logic [3:0] buttons_clean;
    logic [3:0] press_pulse;
    logic [1:0] db_state;

    sga_button_conditioner_if dir_bus ();

    sga_button_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (16)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .buttons_raw   (buttons_raw),
        .current_dir   (current_dir),
        .enable        (enable),
        .dir_bus       (dir_bus),
        .buttons_clean (buttons_clean),
        .press_pulse   (press_pulse),
        .db_state      (db_state)
    );

    typedef struct {
        int         cyc;
        logic [3:0] vec;
    } exp_t;

    exp_t sb_q[$];
    int   cyc;
    int   total;
    int   bad;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Drive a held press and record when its pulse must appear.
    task automatic press(input logic [3:0] pmask);
        exp_t e;
        buttons_raw = ~pmask;
        e.cyc = cyc + 2 + D;
        e.vec = pmask;
        sb_q.push_back(e);
    endtask

    task automatic release_all();
        buttons_raw = 4'b1111;
        tick(D + 4);
    endtask

    task automatic ack_once();
        dir_bus.dir_ack = 1'b1;
        tick(1);
        dir_bus.dir_ack = 1'b0;
    endtask

    // Pulse monitor: every emitted pulse must match the head of the queue.
    always @(negedge clock) begin
        if (press_pulse != 4'b0000) begin
            if (sb_q.size() == 0) begin
                check("pulse_unexpected", {28'd0, press_pulse}, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                $display("pulse cyc=%0d vec=%b exp_cyc=%0d exp_vec=%b", cyc, press_pulse, e.cyc, e.vec);
                check("pulse_vec", {28'd0, press_pulse}, {28'd0, e.vec});
                check("pulse_cyc", cyc, e.cyc);
            end
        end
    end

    initial begin
        cyc             = 0;
        total           = 0;
        bad             = 0;
        reset           = 1'b0;
        buttons_raw     = 4'b1111;
        current_dir     = 2'b01;
        enable          = 1'b1;
        dir_bus.dir_ack = 1'b0;

        // Reset values
        tick(3);
        check("rst_clean", {28'd0, buttons_clean}, 32'hF);
        check("rst_pulse", {28'd0, press_pulse}, 32'h0);
        check("rst_valid", {31'd0, dir_bus.dir_valid}, 32'd0);
        check("rst_code", {30'd0, dir_bus.dir_code}, 32'd1);
        check("rst_db", {30'd0, db_state}, 32'd0);
        reset = 1'b1;
        tick(2);
        check("post_rst_clean", {28'd0, buttons_clean}, 32'hF);

        // Left held while heading right: pulse, clean low, request rejected
        press(4'b1000);
        tick(3);
        check("db_press_wait", {30'd0, db_state}, 32'd1);
        tick(7);
        check("db_pressed", {30'd0, db_state}, 32'd2);
        check("clean_left", {28'd0, buttons_clean}, 32'h7);
        tick(1);
        check("left_rejected", {31'd0, dir_bus.dir_valid}, 32'd0);
        tick(5);
        release_all();
        check("clean_released", {28'd0, buttons_clean}, 32'hF);
        check("db_released", {30'd0, db_state}, 32'd0);

        // Glitch one cycle short of the window: fully suppressed
        enable = 1'b0;
        buttons_raw = 4'b0011;
        tick(5);
        check("glitch_db_wait", {30'd0, db_state}, 32'd1);
        tick(2);
        buttons_raw = 4'b1111;
        tick(12);
        check("glitch_clean", {28'd0, buttons_clean}, 32'hF);
        check("glitch_db", {30'd0, db_state}, 32'd0);

        // Low for exactly the window: accepted; enable=0 blocks the request
        press(4'b0010);
        tick(D);
        buttons_raw = 4'b1111;
        tick(4);
        check("en0_no_request", {31'd0, dir_bus.dir_valid}, 32'd0);
        tick(D + 4);
        check("window_clean", {28'd0, buttons_clean}, 32'hF);
        enable = 1'b1;

        // Up while heading right: request held until ack
        press(4'b0100);
        tick(11);
        check("up_valid", {31'd0, dir_bus.dir_valid}, 32'd1);
        check("up_code", {30'd0, dir_bus.dir_code}, 32'd2);
        release_all();
        check("up_held", {31'd0, dir_bus.dir_valid}, 32'd1);
        ack_once();
        check("up_acked", {31'd0, dir_bus.dir_valid}, 32'd0);
        check("up_code_hold", {30'd0, dir_bus.dir_code}, 32'd2);

        // Left + down together heading up: left wins
        current_dir = 2'b10;
        press(4'b1010);
        tick(11);
        check("prio_valid", {31'd0, dir_bus.dir_valid}, 32'd1);
        check("prio_code", {30'd0, dir_bus.dir_code}, 32'd0);
        release_all();
        ack_once();
        check("prio_acked", {31'd0, dir_bus.dir_valid}, 32'd0);

        // Same pair heading right: left rejected, down not considered
        current_dir = 2'b01;
        press(4'b1010);
        tick(11);
        check("nofall_valid", {31'd0, dir_bus.dir_valid}, 32'd0);
        check("nofall_code", {30'd0, dir_bus.dir_code}, 32'd0);
        release_all();

        // Pending down request; a later up without ack is dropped
        current_dir = 2'b00;
        press(4'b0010);
        tick(11);
        check("down_code", {30'd0, dir_bus.dir_code}, 32'd3);
        release_all();
        press(4'b0100);
        tick(12);
        check("first_wins_valid", {31'd0, dir_bus.dir_valid}, 32'd1);
        check("first_wins_code", {30'd0, dir_bus.dir_code}, 32'd3);
        release_all();

        // Up pulse coincident with ack: replaces the request, valid stays
        press(4'b0100);
        tick(10);
        check("coinc_pulse", {28'd0, press_pulse}, 32'h4);
        ack_once();
        check("replace_valid", {31'd0, dir_bus.dir_valid}, 32'd1);
        check("replace_code", {30'd0, dir_bus.dir_code}, 32'd2);
        release_all();

        // Reset mid-debounce with a request pending
        buttons_raw = 4'b0111;
        tick(5);
        check("pre_rst_db", {30'd0, db_state}, 32'd1);
        buttons_raw = 4'b1111;
        reset = 1'b0;
        #1;
        check("mid_rst_db", {30'd0, db_state}, 32'd0);
        check("mid_rst_valid", {31'd0, dir_bus.dir_valid}, 32'd0);
        check("mid_rst_code", {30'd0, dir_bus.dir_code}, 32'd1);
        check("mid_rst_clean", {28'd0, buttons_clean}, 32'hF);
        tick(2);
        reset = 1'b1;
        tick(20);
        check("post_rst_valid", {31'd0, dir_bus.dir_valid}, 32'd0);
        check("sb_empty", sb_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
